// File: rtl/pulse_burst_meter.sv
// pulse_burst_meter: groups edges of an asynchronous pulse train into bursts.
// A burst ends once GAP consecutive low samples are seen after synchronisation.
// At burst end the pulse count, the last and the largest high-width, and an
// overflow flag are published, together with a one-cycle done strobe.
//
// Ports:
//   clock      rising-edge system clock
//   reset      synchronous active-high reset
//   signal     asynchronous pulse train input
//   active     high while a burst is in progress
//   done       one-cycle strobe on burst completion
//   count      pulses in the last completed burst
//   width      high-width of the last pulse in the last completed burst
//   max_width  largest high-width in the last completed burst
//   ovf        a counter saturated during the last completed burst
module pulse_burst_meter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WID_W = 8,
    parameter int unsigned GAP   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    output logic             active,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [WID_W-1:0] width,
    output logic [WID_W-1:0] max_width,
    output logic             ovf
);

    localparam int unsigned        GCNT_W   = 8;
    localparam logic [CNT_W-1:0]   PCNT_MAX = '1;
    localparam logic [WID_W-1:0]   HCNT_MAX = '1;
    // gcnt holds the low samples already seen; the burst ends on the GAP-th one
    localparam logic [GCNT_W-1:0]  GAP_LAST = GCNT_W'(GAP - 1);
    localparam bit                 GAP_ONE  = (GAP == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic s1_q, s2_q, s3_q;
    logic rise;
    logic burst_end;

    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [WID_W-1:0]  hcnt_q, hcnt_d;
    logic [WID_W-1:0]  lastw_q, lastw_d;
    logic [WID_W-1:0]  maxw_q, maxw_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic              ovf_acc_q, ovf_acc_d;

    logic              active_q, active_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WID_W-1:0]  width_q, width_d;
    logic [WID_W-1:0]  max_width_q, max_width_d;
    logic              ovf_q, ovf_d;

    assign rise = s2_q & ~s3_q;

    // Burst terminates on the GAP-th consecutive low sample of s2
    assign burst_end = (!s2_q) &&
                       (((state_q == ST_HIGH) && GAP_ONE) ||
                        ((state_q == ST_LOW) && (gcnt_q == GAP_LAST)));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: if (!s2_q) state_d = burst_end ? ST_IDLE : ST_LOW;
            ST_LOW: begin
                // in LOW, s2 was low last cycle, so s2 high is always a rise
                if (s2_q)           state_d = ST_HIGH;
                else if (burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and result update logic
    always_comb begin
        pcnt_d      = pcnt_q;
        hcnt_d      = hcnt_q;
        lastw_d     = lastw_q;
        maxw_d      = maxw_q;
        gcnt_d      = gcnt_q;
        ovf_acc_d   = ovf_acc_q;
        done_d      = 1'b0;
        count_d     = count_q;
        width_d     = width_q;
        max_width_d = max_width_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    pcnt_d    = CNT_W'(1);
                    hcnt_d    = WID_W'(1);
                    maxw_d    = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (s2_q) begin
                    if (hcnt_q == HCNT_MAX) ovf_acc_d = 1'b1;
                    else                    hcnt_d    = hcnt_q + WID_W'(1);
                end else begin
                    lastw_d = hcnt_q;
                    maxw_d  = (hcnt_q > maxw_q) ? hcnt_q : maxw_q;
                    gcnt_d  = GCNT_W'(1);
                end
            end
            ST_LOW: begin
                if (s2_q) begin
                    if (pcnt_q == PCNT_MAX) ovf_acc_d = 1'b1;
                    else                    pcnt_d    = pcnt_q + CNT_W'(1);
                    hcnt_d = WID_W'(1);
                end else if (!burst_end) begin
                    gcnt_d = gcnt_q + GCNT_W'(1);
                end
            end
            default: ;
        endcase

        // Publish using the updated width trackers so a HIGH->IDLE end is covered
        if (burst_end) begin
            done_d      = 1'b1;
            count_d     = pcnt_q;
            width_d     = lastw_d;
            max_width_d = maxw_d;
            ovf_d       = ovf_acc_d;
        end

        active_d = (state_d != ST_IDLE);
    end

    // Synchroniser, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            pcnt_q      <= '0;
            hcnt_q      <= '0;
            lastw_q     <= '0;
            maxw_q      <= '0;
            gcnt_q      <= '0;
            ovf_acc_q   <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            width_q     <= '0;
            max_width_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q        <= signal;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            pcnt_q      <= pcnt_d;
            hcnt_q      <= hcnt_d;
            lastw_q     <= lastw_d;
            maxw_q      <= maxw_d;
            gcnt_q      <= gcnt_d;
            ovf_acc_q   <= ovf_acc_d;
            active_q    <= active_d;
            done_q      <= done_d;
            count_q     <= count_d;
            width_q     <= width_d;
            max_width_q <= max_width_d;
            ovf_q       <= ovf_d;
        end
    end

    assign active    = active_q;
    assign done      = done_q;
    assign count     = count_q;
    assign width     = width_q;
    assign max_width = max_width_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_burst_meter.sv
// tb_pulse_burst_meter: directed bench for pulse_burst_meter with narrow
// counters (CNT_W=3, WID_W=4) so that saturation is reachable in short runs.
module tb_pulse_burst_meter;

    localparam int unsigned CNT_W = 3;
    localparam int unsigned WID_W = 4;
    localparam int unsigned GAP   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             signal;
    logic             active;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [WID_W-1:0] width;
    logic [WID_W-1:0] max_width;
    logic             ovf;

    int unsigned nchecks = 0;
    int unsigned npass   = 0;
    int unsigned ndone   = 0;
    int          dcounts[$];

    pulse_burst_meter #(
        .CNT_W(CNT_W),
        .WID_W(WID_W),
        .GAP  (GAP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .signal   (signal),
        .active   (active),
        .done     (done),
        .count    (count),
        .width    (width),
        .max_width(max_width),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // Record every done strobe and the count it published
    always @(negedge clock) begin
        if (done) begin
            ndone++;
            dcounts.push_back(int'(count));
        end
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        nchecks++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_res(input string tag, input int unsigned c, input int unsigned w,
                             input int unsigned m, input int unsigned o);
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_width"}, int'(width), w);
        chk({tag, "_maxw"},  int'(max_width), m);
        chk({tag, "_ovf"},   int'(ovf), o);
    endtask

    // Set the input for the next rising edge
    task automatic tick(input logic v);
        @(negedge clock);
        signal = v;
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    int unsigned base;
    int          qbase;

    initial begin
        signal = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_active", int'(active), 0);
        chk("rst_done",   int'(done), 0);
        check_res("rst", 0, 0, 0, 0);
        reset = 1'b0;
        idle(2);

        // Three 2-high/2-low pulses then 10 lows; tick k drives edge k and
        // observes edge k-1: active from tick 3 through 15, done at tick 16.
        base = ndone;
        for (int k = 0; k < 22; k++) begin
            tick((k < 12) && ((k % 4) < 2));
            chk($sformatf("t1_active_%0d", k), int'(active), ((k >= 3) && (k <= 15)) ? 1 : 0);
            chk($sformatf("t1_done_%0d", k),   int'(done),   (k == 16) ? 1 : 0);
        end
        idle(4);
        chk("t1_ndone", ndone - base, 1);
        check_res("t1", 3, 2, 2, 0);

        // Widths 1, 5, 3 separated by 2 lows
        base = ndone;
        pulse(1, 2); pulse(5, 2); pulse(3, 0); idle(12);
        chk("t2_ndone", ndone - base, 1);
        check_res("t2", 3, 3, 5, 0);

        // Gap of GAP-1 lows keeps one burst
        base = ndone;
        pulse(2, 3); pulse(2, 0); idle(12);
        chk("t3a_ndone", ndone - base, 1);
        check_res("t3a", 2, 2, 2, 0);

        // Gap of GAP lows splits into two bursts; the second rise lands right after done
        base  = ndone;
        qbase = dcounts.size();
        pulse(2, 4); pulse(2, 0); idle(12);
        chk("t3b_ndone", ndone - base, 2);
        chk("t3b_count0", dcounts[qbase], 1);
        chk("t3b_count1", dcounts[qbase + 1], 1);
        check_res("t3b", 1, 2, 2, 0);

        // Pulse count saturates at 7, then ovf clears on the next burst
        base = ndone;
        repeat (9) pulse(1, 1);
        idle(12);
        chk("t4_ndone", ndone - base, 1);
        check_res("t4", 7, 1, 1, 1);
        pulse(1, 0); idle(12);
        chk("t4b_ndone", ndone - base, 2);
        check_res("t4b", 1, 1, 1, 0);

        // Stuck high for 20 cycles: width saturates at 15, no done while high
        base = ndone;
        pulse(20, 0);
        chk("t5_active_high", int'(active), 1);
        chk("t5_no_done", ndone - base, 0);
        idle(12);
        chk("t5_ndone", ndone - base, 1);
        check_res("t5", 1, 15, 15, 1);

        // Reset mid-burst after 2 pulses clears outputs and suppresses done
        base = ndone;
        pulse(2, 2); pulse(2, 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_active", int'(active), 0);
        chk("t6_done",   int'(done), 0);
        check_res("t6_rst", 0, 0, 0, 0);
        idle(12);
        chk("t6_no_done", ndone - base, 0);
        pulse(3, 0); idle(12);
        chk("t6_ndone", ndone - base, 1);
        check_res("t6", 1, 3, 3, 0);

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
